// File: rtl/souper_aud_rx.sv
// Souper audio expansion receiver: synchronises the toggling aud_req_n/aud_com port,
// turns every request toggle into a push of the command byte into an FWFT FIFO.
module souper_aud_rx #(
  parameter int DEPTH_LOG2  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            aud_com,
  input  logic                  aud_req_n,
  output logic [7:0]            cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]    ARM_LAST   = ARM_W'(SYNC_STAGES);
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {ST_ARM, ST_RUN} state_t;

  logic [SYNC_STAGES-1:0] r_req_s;
  logic [7:0]             r_data_s [SYNC_STAGES];
  logic                   r_req_last;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic [7:0]             r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  r_wr_ptr;
  logic [DEPTH_LOG2-1:0]  r_rd_ptr;
  logic [DEPTH_LOG2:0]    r_level;
  logic                   r_overflow;

  logic       w_req_sync;
  logic [7:0] w_data_sync;
  logic       w_toggle;
  logic       w_push;
  logic       w_full;
  logic       w_pop;
  logic       w_wr_en;
  logic       w_drop;

  // Data travels through the same depth as the request so both land together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_s <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_s[i] <= '0;
      r_req_last <= 1'b1;
    end else begin
      r_req_s     <= {r_req_s[SYNC_STAGES-2:0], aud_req_n};
      r_data_s[0] <= aud_com;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_s[i] <= r_data_s[i-1];
      r_req_last  <= w_req_sync;
    end
  end

  assign w_req_sync  = r_req_s[SYNC_STAGES-1];
  assign w_data_sync = r_data_s[SYNC_STAGES-1];
  assign w_toggle    = w_req_sync ^ r_req_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_ARM;
      r_arm_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_ARM && r_arm_cnt != ARM_LAST) r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  // ARM lets the synchroniser flush so a line held low through reset is not a command.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      ST_ARM:  if (r_arm_cnt == ARM_LAST) w_state_next = ST_RUN;
      ST_RUN:  w_push = w_toggle;
      default: w_state_next = ST_ARM;
    endcase
  end

  assign w_full    = (r_level == FULL_LEVEL);
  assign cmd_valid = (r_level != '0);
  assign w_pop     = cmd_valid & cmd_ready;
  // When full, a concurrent pop frees the slot that wr_ptr aliases, so the write is safe.
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_data_sync;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign cmd_data   = cmd_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule
